snes_color_mapper: RTL and testbench

Parametrised, registered successor to the SNES button-to-colour decoder. Synchronises and debounces NUM_BTN active-low SNES button lines, detects debounced presses, and latches the colour assigned to the winning button from a per-button palette. The latched colour holds until the next press and drives the VGA colour generator's RGB inputs. An optional fade mode ramps the outputs toward the new colour instead of jumping.

---
 rtl/snes_color_mapper.sv | 155 +++++++++++++++
 tb/tb_snes_color_mapper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/snes_color_mapper.sv
// SNES button-to-colour mapper: per-button 2-flop sync + debounce, press arbitration, latched palette colour.
// Define SNES_COLOR_FADE_EN to ramp the outputs toward a new colour one step per FADE_DIV cycles.

module snes_btn_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic stable_o,
  output logic fall_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          mismatch, accept;

  // Accept once DEB_CYCLES+1 consecutive synced samples disagree with the stable level.
  assign mismatch = sync_q[1] != stable_q;
  assign accept   = mismatch && (cnt_q == CW'(DEB_CYCLES));

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (accept)        stable_d = sync_q[1];
    else if (mismatch) cnt_d    = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], btn_n_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign fall_o   = accept & stable_q;
endmodule

module snes_color_mapper #(
  parameter int NUM_BTN    = 12,
  parameter int CBITS      = 4,
  parameter int DEB_CYCLES = 250000,
  parameter int FADE_DIV   = 65536
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BTN-1:0]         btn_n,
  input  logic [NUM_BTN*3*CBITS-1:0] palette,
  output logic [CBITS-1:0]           red,
  output logic [CBITS-1:0]           green,
  output logic [CBITS-1:0]           blue,
  output logic [NUM_BTN-1:0]         btn_stable,
  output logic                       press_strobe,
  output logic [3:0]                 active_idx,
  output logic                       settled
);
  localparam int PW = 3 * CBITS;

  if (NUM_BTN < 1 || NUM_BTN > 16 || DEB_CYCLES < 1 || FADE_DIV < 1 || CBITS < 1) begin : g_param_chk
    $error("snes_color_mapper: parameter out of range");
  end

  logic [NUM_BTN-1:0] fall;
  logic               win_vld;
  logic [3:0]         win_idx;
  logic [PW-1:0]      win_col;
  logic [PW-1:0]      tgt_q, tgt_d, rgb_q, rgb_d;
  logic [3:0]         idx_q, idx_d;
  logic               strobe_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    snes_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_n_i  (btn_n[g]),
      .stable_o (btn_stable[g]),
      .fall_o   (fall[g])
    );
  end

  // Highest index wins among presses accepted on the same edge.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_col = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (fall[i]) begin
        win_vld = 1'b1;
        win_idx = 4'(i);
        win_col = palette[i*PW +: PW];
      end
    end
  end

  assign idx_d = win_vld ? win_idx : idx_q;
  assign tgt_d = win_vld ? win_col : tgt_q;

`ifdef SNES_COLOR_FADE_EN
  localparam int TW = $clog2(FADE_DIV + 1);

  logic [TW-1:0] tick_q;
  logic          tick;

  assign tick = tick_q == TW'(FADE_DIV - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick ? '0 : tick_q + TW'(1);
  end

  // Each channel moves one code toward the target per tick; equality stops it, so no overshoot.
  always_comb begin
    rgb_d = rgb_q;
    if (tick) begin
      for (int c = 0; c < 3; c++) begin
        if (rgb_q[c*CBITS +: CBITS] < tgt_q[c*CBITS +: CBITS])
          rgb_d[c*CBITS +: CBITS] = rgb_q[c*CBITS +: CBITS] + CBITS'(1);
        else if (rgb_q[c*CBITS +: CBITS] > tgt_q[c*CBITS +: CBITS])
          rgb_d[c*CBITS +: CBITS] = rgb_q[c*CBITS +: CBITS] - CBITS'(1);
      end
    end
  end
`else
  assign rgb_d = tgt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      idx_q    <= '0;
      tgt_q    <= '0;
      rgb_q    <= '0;
    end else begin
      strobe_q <= win_vld;
      idx_q    <= idx_d;
      tgt_q    <= tgt_d;
      rgb_q    <= rgb_d;
    end
  end

  assign red          = rgb_q[3*CBITS-1:2*CBITS];
  assign green        = rgb_q[2*CBITS-1:CBITS];
  assign blue         = rgb_q[CBITS-1:0];
  assign press_strobe = strobe_q;
  assign active_idx   = idx_q;
  assign settled      = rgb_q == tgt_q;
endmodule

// File: tb/tb_snes_color_mapper.sv
// Bench for snes_color_mapper: directed scenarios plus random button traffic, every cycle compared
// against a reference model built from the debounce/press/colour rules.
module tb_snes_color_mapper;
  localparam int NB = 12, CB = 4, DEB = 4, FDIV = 2, PW = 3 * CB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NB-1:0]    btn_n = '1;
  logic [NB*PW-1:0] palette = '0;
  logic [CB-1:0]    red, green, blue;
  logic [NB-1:0]    btn_stable;
  logic             press_strobe, settled;
  logic [3:0]       active_idx;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: synced sample = raw sample two edges back; a level flips after DEB+1
  // consecutive disagreeing synced samples.
  logic [NB-1:0] m_s1 = '1, m_s2 = '1, m_stab = '1;
  int            m_run [NB];
  logic [PW-1:0] m_tgt = '0, m_rgb = '0;
  logic          m_strobe = 1'b0;
  logic [3:0]    m_idx = '0;
  int            m_edges = 0;

  snes_color_mapper #(.NUM_BTN(NB), .CBITS(CB), .DEB_CYCLES(DEB), .FADE_DIV(FDIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_n        (btn_n),
    .palette      (palette),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .btn_stable   (btn_stable),
    .press_strobe (press_strobe),
    .active_idx   (active_idx),
    .settled      (settled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

`ifdef SNES_COLOR_FADE_EN
  function automatic logic [CB-1:0] step_to(input logic [CB-1:0] cur, input logic [CB-1:0] tgt);
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction
`endif

  task automatic model_edge();
    logic [NB-1:0] falls;
    logic [PW-1:0] old_tgt;
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; m_stab = '1;
      m_tgt = '0; m_rgb = '0; m_strobe = 1'b0; m_idx = '0; m_edges = 0;
      foreach (m_run[i]) m_run[i] = 0;
      return;
    end
    falls   = '0;
    old_tgt = m_tgt;
    for (int i = 0; i < NB; i++) begin
      if (m_s2[i] != m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB + 1) begin
          falls[i]  = m_stab[i];
          m_stab[i] = ~m_stab[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2     = m_s1;
    m_s1     = btn_n;
    m_strobe = |falls;
    for (int i = NB - 1; i >= 0; i--) begin
      if (falls[i]) begin
        m_idx = 4'(i);
        m_tgt = palette[i*PW +: PW];
        break;
      end
    end
    m_edges++;
`ifdef SNES_COLOR_FADE_EN
    if (m_edges % FDIV == 0)
      for (int c = 0; c < 3; c++) m_rgb[c*CB +: CB] = step_to(m_rgb[c*CB +: CB], old_tgt[c*CB +: CB]);
`else
    m_rgb = old_tgt;
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("strobe",     32'(press_strobe),        32'(m_strobe));
    chk("active_idx", 32'(active_idx),          32'(m_idx));
    chk("btn_stable", 32'(btn_stable),          32'(m_stab));
    chk("rgb",        32'({red, green, blue}),  32'(m_rgb));
    chk("settled",    32'(settled),             32'(m_rgb == m_tgt));
  endtask

  // Runs n cycles; reports the first cycle (1-based) with a strobe and the number of strobes.
  task automatic run(input int n, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int j = 1; j <= n; j++) begin
      cycle();
      if (press_strobe) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
  endtask

  initial begin
    int first, cnt, tot, b, e;
    foreach (m_run[i]) m_run[i] = 0;
    for (int i = 0; i < NB; i++) palette[i*PW +: PW] = PW'($urandom);
    palette[0*PW +: PW] = 12'hF80;
    palette[1*PW +: PW] = 12'h000;
    palette[2*PW +: PW] = 12'h5A3;
    palette[3*PW +: PW] = 12'h3C7;
    palette[8*PW +: PW] = 12'h0FF;
    palette[9*PW +: PW] = 12'hE21;

    // Reset
    rst_n = 1'b0;
    run(2, first, cnt);
    chk("reset_rgb",     32'({red, green, blue}), 32'h000);
    chk("reset_stable",  32'(btn_stable),         32'hFFF);
    chk("reset_settled", 32'(settled),            32'h1);
    chk("reset_strobe",  32'(press_strobe),       32'h0);
    rst_n = 1'b1;
    run(3, first, cnt);

    // Clean press of button 8, then release: colour must hold
    btn_n[8] = 1'b0;
    run(7, first, cnt);
    chk("clean_strobe_edge", 32'(first), 32'd7);
    chk("clean_idx",         32'(active_idx), 32'd8);
`ifndef SNES_COLOR_FADE_EN
    run(1, first, cnt);
    chk("clean_rgb_next_edge", 32'({red, green, blue}), 32'h0FF);
`endif
    btn_n[8] = 1'b1;
    run(40, first, cnt);
    chk("release_holds", 32'({red, green, blue}), 32'h0FF);

    // Bounce on button 3: one strobe, six edges after the final fall
    btn_n[3] = 1'b0; run(3, first, cnt); tot = cnt;
    btn_n[3] = 1'b1; run(1, first, cnt); tot += cnt;
    btn_n[3] = 1'b0; run(10, first, cnt); tot += cnt;
    chk("bounce_count", 32'(tot),   32'd1);
    chk("bounce_edge",  32'(first), 32'd7);
    btn_n[3] = 1'b1;
    run(40, first, cnt);

    // Short glitch on button 6: no strobe, colour unchanged
    btn_n[6] = 1'b0; run(2, first, cnt); tot = cnt;
    btn_n[6] = 1'b1; run(12, first, cnt); tot += cnt;
    chk("glitch_count", 32'(tot), 32'd0);
    chk("glitch_rgb",   32'({red, green, blue}), 32'h3C7);

    // Simultaneous 1 and 9, then 2 while 9 held
    btn_n[1] = 1'b0; btn_n[9] = 1'b0;
    run(10, first, cnt);
    chk("simul_count", 32'(cnt), 32'd1);
    chk("simul_idx",   32'(active_idx), 32'd9);
    btn_n[2] = 1'b0;
    run(40, first, cnt);
    chk("held_idx", 32'(active_idx), 32'd2);
    chk("held_rgb", 32'({red, green, blue}), 32'h5A3);
    btn_n = '1;
    run(12, first, cnt);

    // Reset two cycles into a debounce: fresh full debounce from the release
    btn_n[5] = 1'b0;
    run(2, first, cnt);
    rst_n = 1'b0;
    run(1, first, cnt);
    chk("midrst_rgb", 32'({red, green, blue}), 32'h000);
    rst_n = 1'b1;
    run(12, first, cnt);
    chk("midrst_edge",  32'(first), 32'd7);
    chk("midrst_count", 32'(cnt),   32'd1);
    btn_n[5] = 1'b1;
    run(12, first, cnt);

`ifdef SNES_COLOR_FADE_EN
    // Ramp 0/0/0 -> F/8/0, reverse mid-fade with a press for 0/0/0
    rst_n = 1'b0; run(1, first, cnt); rst_n = 1'b1;
    btn_n[0] = 1'b0; run(40, first, cnt);
    chk("fade_rgb", 32'({red, green, blue}), 32'hF80);
    btn_n[0] = 1'b1; run(8, first, cnt);
    btn_n[1] = 1'b0; run(14, first, cnt);
    btn_n[1] = 1'b1; run(6, first, cnt);
    btn_n[0] = 1'b0; run(50, first, cnt);
    chk("fade_back", 32'({red, green, blue}), 32'hF80);
    btn_n = '1;
    run(12, first, cnt);
`endif

    // Random traffic with occasional palette edits and resets
    for (int it = 0; it < 300; it++) begin
      b = $urandom_range(NB - 1, 0);
      btn_n[b] = ~btn_n[b];
      if ($urandom_range(15, 0) == 0) begin
        e = $urandom_range(NB - 1, 0);
        palette[e*PW +: PW] = PW'($urandom);
      end
      if ($urandom_range(63, 0) == 0) rst_n = 1'b0;
      run($urandom_range(8, 1), first, cnt);
      rst_n = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
